// File: rtl/adder_tree_accumulator_if.sv
// Valid/ready bundle between the adder-tree root, the frame accumulator and
// its consumer; widths follow the accumulator's derived sizing.
interface adder_tree_accumulator_if #(
  parameter int DATAW     = 11,
  parameter int NUM_BEATS = 16
);
  localparam int ACCW  = DATAW + $clog2(NUM_BEATS);
  localparam int BIDXW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACCW-1:0]  out_data;
  logic [BIDXW-1:0] beat_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, beat_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, beat_idx
  );
endinterface

// File: rtl/adder_tree_accumulator.sv
// Accumulates NUM_BEATS signed tree-root sums into one widened frame total
// and presents it on a registered valid/ready output.
module adder_tree_accumulator #(
  parameter int DATAW     = 11,
  parameter int NUM_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  adder_tree_accumulator_if.slave bus
);
  localparam int ACCW  = DATAW + $clog2(NUM_BEATS);
  localparam int BIDXW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BIDXW-1:0] LAST_IDX = BIDXW'(NUM_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fsm_t;

  fsm_t                   state_r;
  fsm_t                   state_nxt_s;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] acc_nxt_s;
  logic signed [ACCW-1:0] out_data_r;
  logic signed [ACCW-1:0] out_data_nxt_s;
  logic                   out_valid_r;
  logic                   out_valid_nxt_s;
  logic [BIDXW-1:0]       beat_idx_r;
  logic [BIDXW-1:0]       beat_idx_nxt_s;
  logic signed [ACCW-1:0] in_sext_s;
  logic signed [ACCW-1:0] sum_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   last_s;

  // The output slot is free when empty or being drained this cycle; clear does not gate it.
  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_s     = (beat_idx_r == LAST_IDX);
  assign in_sext_s  = ACCW'($signed(bus.in_data));
  assign sum_s      = acc_r + in_sext_s;

  // Next-state and datapath update; clear overrides any beat or drain in the same cycle.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    beat_idx_nxt_s  = beat_idx_r;

    if (clear) begin
      state_nxt_s     = IDLE;
      acc_nxt_s       = {ACCW{1'b0}};
      out_valid_nxt_s = 1'b0;
      beat_idx_nxt_s  = {BIDXW{1'b0}};
    end else begin
      if (out_valid_r && bus.out_ready) begin
        out_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = out_valid_r;
      end

      if (accept_s && last_s) begin
        out_data_nxt_s  = sum_s;
        out_valid_nxt_s = 1'b1;
        acc_nxt_s       = {ACCW{1'b0}};
        beat_idx_nxt_s  = {BIDXW{1'b0}};
      end else if (accept_s) begin
        acc_nxt_s       = sum_s;
        beat_idx_nxt_s  = beat_idx_r + BIDXW'(1);
      end else begin
        acc_nxt_s       = acc_r;
        beat_idx_nxt_s  = beat_idx_r;
      end

      case (state_r)
        IDLE: begin
          if (accept_s && !last_s) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ACCUM: begin
          if (accept_s && last_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, accumulator and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACCW{1'b0}};
      out_data_r  <= {ACCW{1'b0}};
      out_valid_r <= 1'b0;
      beat_idx_r  <= {BIDXW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      beat_idx_r  <= beat_idx_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.beat_idx  = beat_idx_r;
endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Drives a 4-beat and a 1-beat accumulator with identical directed and random
// stimulus and compares every output against a frame-level queue model.
module tb_adder_tree_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  adder_tree_accumulator_if #(.DATAW(11), .NUM_BEATS(4)) bus4 ();
  adder_tree_accumulator_if #(.DATAW(11), .NUM_BEATS(1)) bus1 ();

  adder_tree_accumulator #(.DATAW(11), .NUM_BEATS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus4)
  );
  adder_tree_accumulator #(.DATAW(11), .NUM_BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   frame_q[$];
  int   m_od4 = 0;
  logic m_ov4 = 1'b0;
  int   m_od1 = 0;
  logic m_ov1 = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_od4 = 0;
    m_ov4 = 1'b0;
    m_od1 = 0;
    m_ov1 = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic v, input int d, input logic ordy, input logic clr);
    logic acc4;
    logic acc1;
    @(negedge clk);
    bus4.in_valid = v;  bus4.in_data = d[10:0];  bus4.out_ready = ordy;
    bus1.in_valid = v;  bus1.in_data = d[10:0];  bus1.out_ready = ordy;
    clear = clr;
    #1;
    check("in_ready4",  bus4.in_ready,  !m_ov4 || ordy);
    check("out_valid4", bus4.out_valid, m_ov4);
    check("out_data4",  $signed(bus4.out_data), m_od4);
    check("beat_idx4",  bus4.beat_idx,  frame_q.size());
    check("in_ready1",  bus1.in_ready,  !m_ov1 || ordy);
    check("out_valid1", bus1.out_valid, m_ov1);
    check("out_data1",  $signed(bus1.out_data), m_od1);
    check("beat_idx1",  bus1.beat_idx,  0);
    @(posedge clk);
    acc4 = v && (!m_ov4 || ordy);
    acc1 = v && (!m_ov1 || ordy);
    if (clr) begin
      frame_q.delete();
      m_ov4 = 1'b0;
      m_ov1 = 1'b0;
    end else begin
      if (m_ov4 && ordy) m_ov4 = 1'b0;
      if (acc4) begin
        frame_q.push_back(d);
        if (frame_q.size() == 4) begin
          m_od4 = 0;
          foreach (frame_q[i]) m_od4 += frame_q[i];
          m_ov4 = 1'b1;
          frame_q.delete();
        end
      end
      if (m_ov1 && ordy) m_ov1 = 1'b0;
      if (acc1) begin
        m_od1 = d;
        m_ov1 = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = 11'd0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 11'd0; bus1.out_ready = 1'b0;
    model_reset();
    #2;
    check("rst_in_ready4",  bus4.in_ready, 1);
    check("rst_out_valid4", bus4.out_valid, 0);
    check("rst_out_data4",  $signed(bus4.out_data), 0);
    check("rst_beat_idx4",  bus4.beat_idx, 0);
    #6 rst_n = 1'b1;

    // Basic frame: 100 - 50 + 1023 - 1024 = 49
    step(1'b1, 100, 1'b1, 1'b0);
    step(1'b1, -50, 1'b1, 1'b0);
    step(1'b1, 1023, 1'b1, 1'b0);
    step(1'b1, -1024, 1'b1, 1'b0);
    #2;
    check("basic_valid", bus4.out_valid, 1);
    check("basic_total", $signed(bus4.out_data), 49);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Extremes, back-to-back frames
    for (int i = 0; i < 4; i++) step(1'b1, -1024, 1'b1, 1'b0);
    #2;
    check("min_total", $signed(bus4.out_data), -4096);
    for (int i = 0; i < 4; i++) step(1'b1, 1023, 1'b1, 1'b0);
    #2;
    check("max_total", $signed(bus4.out_data), 4092);
    check("max_valid", bus4.out_valid, 1);

    // Backpressure: result held, input stalled, then released
    for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b1, 1'b0);
    #2;
    check("bp_valid_drop", bus4.out_valid, 0);
    check("bp_beat_idx",   bus4.beat_idx, 1);
    step(1'b0, 0, 1'b1, 1'b0);

    // Clear mid-frame drops the offered beat
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 6, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1, 1'b0);
    #2;
    check("clear_total", $signed(bus4.out_data), 4);
    check("clear_valid", bus4.out_valid, 1);

    // Async reset between edges after three beats
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b1, 1'b0);
    #3;
    bus4.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid4", bus4.out_valid, 0);
    check("arst_out_data4",  $signed(bus4.out_data), 0);
    check("arst_beat_idx4",  bus4.beat_idx, 0);
    check("arst_in_ready4",  bus4.in_ready, 1);
    check("arst_out_data1",  $signed(bus1.out_data), 0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b1, 1'b0);
    #2;
    check("arst_total", $signed(bus4.out_data), 8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 2047)) - 1024,
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/adder_tree_accumulator.md
# adder_tree_accumulator

Sequential stage directly downstream of the adder-tree reduction. It consumes one signed reduced sum per accepted beat and accumulates `NUM_BEATS` consecutive beats into a widened signed total. It presents that total on a registered valid/ready output. It is the point where the combinational tree result becomes a pipelined, flow-controlled frame result.

## Interface
- `DATAW`, default 11: width of the signed tree-root sum entering the block.
- `NUM_BEATS`, default 16: beats per frame; must be ≥1.
- `ACCW`, default `DATAW + $clog2(NUM_BEATS)` (for `NUM_BEATS` = 1, `ACCW` = `DATAW`): accumulator and output width. Derived; not overridden.
- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame abort.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  DATAW  signed tree-root sum.
- `out_valid`  out  1  frame result held on `out_data`.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  ACCW  signed frame total.
- `beat_idx`  out  $clog2(NUM_BEATS) (min 1)  number of beats already accepted in the current frame.

## Operation
- State machine `fsm`: IDLE (`beat_idx`=0, no partial sum) and ACCUM (`beat_idx`>0).
- `out_valid` is a separate output-register flag and is not a state.
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. The output register can be drained and refilled in the same cycle.
- Each accepted non-last beat does three things:
  - `acc <= acc + sext(in_data)`.
  - `beat_idx` increments.
  - IDLE→ACCUM on the first beat.
- Last beat (accepted while `beat_idx == NUM_BEATS-1`):
  - `out_data <= acc + sext(in_data)`; `out_valid <= 1`.
  - `acc <= 0`; `beat_idx <= 0`; state returns to IDLE.
- With `NUM_BEATS`=1, every beat is last and the state machine stays in IDLE.
- Output handshake:
  - `out_valid && out_ready` clears `out_valid` next cycle, unless a last beat is accepted in that same cycle, in which case the new total loads and `out_valid` stays 1.
  - `out_data` is stable while `out_valid && !out_ready`.
- Arithmetic:
  - Two's-complement with sign extension of `in_data` to `ACCW`.
  - `ACCW` bounds the worst case (`NUM_BEATS` × −2^(DATAW−1)), so overflow cannot occur. No saturation and no wrap handling.
- `clear` (synchronous, highest priority after reset) does the following next cycle:
  - `acc`, `beat_idx` and `out_valid` go to 0; state goes to IDLE.
  - A beat offered in the same cycle is not accumulated. `in_ready` is still driven by the formula above; `clear` does not gate it, so the upstream side may see a handshake that is dropped.
  - Any pending result is discarded.
- Reset: `acc`=0, `beat_idx`=0, `out_data`=0, `out_valid`=0, state IDLE, immediately on `rst_n` falling, independent of `clk`. `in_ready` reads 1 during and after reset. A frame in progress at reset is lost.

## Timing
- Latency: the result is visible (`out_valid`=1) the cycle after the last beat is accepted.
- Throughput: one beat per cycle sustained when `out_ready`=1. Frames back-to-back with no bubble.
- With `out_ready` low and `out_valid` high, `in_ready` is low. The input stalls on the last-beat boundary and also on any beat: the accumulator does not advance while the result is unconsumed.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`.
- `in_ready` is combinational from `out_valid` and `out_ready` only; there is no path from `in_valid`.
- All other outputs are registered.

## Test plan
All scenarios use `DATAW`=11 and `NUM_BEATS`=4 (`ACCW`=13) unless noted.
- **Basic frame.** Beats 100, −50, 1023, −1024 with `out_ready`=1 → `out_data`=49, `out_valid`=1 for exactly one cycle, one cycle after the 4th accept; `beat_idx` runs 0,1,2,3,0.
- **Extremes.** 4×−1024 → −4096; the next frame 4×1023 → 4092, back-to-back with no idle cycle; no overflow.
- **Backpressure.** After a result, hold `out_ready`=0 with `in_valid`=1 and `in_data`=7 → `in_ready`=0, `out_data` stable, `beat_idx` frozen. Raising `out_ready` → the beat is accepted in that same cycle and `out_valid` drops next cycle.
- **Clear mid-frame.** Beats 5, 6, then `clear` with `in_valid`=1 and `in_data`=9 → 9 is not accumulated and `beat_idx`=0. Then beats 1, 1, 1, 1 → `out_data`=4.
- **Async reset.** After 3 beats, drop `rst_n` between clock edges → `out_valid`, `out_data` and `beat_idx` are 0 before the next edge. After release, a fresh frame of 2, 2, 2, 2 → 8.
- **Single-beat frames.** `NUM_BEATS`=1, one beat per cycle, `out_ready`=1 → `out_data` equals `in_data` delayed one cycle, `out_valid` is continuously 1, and `beat_idx` stays 0.
